// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// States, opcode/funct fields and datapath mux select codes.
package mc_pkg;

  typedef enum logic [4:0] {
    S_HALT      = 5'd0,
    S_FETCH     = 5'd1,
    S_DECODE    = 5'd2,
    S_MEM_ADDR  = 5'd3,
    S_MEM_READ  = 5'd4,
    S_MEM_WB    = 5'd5,
    S_MEM_WRITE = 5'd6,
    S_R_EXEC    = 5'd7,
    S_R_WB      = 5'd8,
    S_I_EXEC    = 5'd9,
    S_I_WB      = 5'd10,
    S_BRANCH    = 5'd11,
    S_JUMP      = 5'd12,
    S_JAL       = 5'd13,
    S_JR        = 5'd14,
    S_TRAP      = 5'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam logic [1:0] PCS_PLUS4 = 2'b00;
  localparam logic [1:0] PCS_ALU   = 2'b01;
  localparam logic [1:0] PCS_JUMP  = 2'b10;
  localparam logic [1:0] PCS_RS    = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_RFN = 2'b10;
  localparam logic [1:0] ALU_IOP = 2'b11;

  localparam logic [2:0] SRCB_RT     = 3'b000;
  localparam logic [2:0] SRCB_FOUR   = 3'b001;
  localparam logic [2:0] SRCB_SIMM   = 3'b010;
  localparam logic [2:0] SRCB_SIMMSH = 3'b011;
  localparam logic [2:0] SRCB_ZIMM   = 3'b100;
  localparam logic [2:0] SRCB_SHAMT  = 3'b101;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_control_unit_mem_wait.sv
// Memory wait counter: counts not-ready cycles in a memory state
// and flags a timeout on the last allowed cycle.
module mc_mem_wait #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_active,
  input  logic i_ready,
  output logic o_timeout
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_active && !i_ready) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  // This cycle is the TIMEOUT-th not-ready one; ready here still wins.
  assign o_timeout = i_active && !i_ready && (r_cnt == LIMIT);

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM with memory handshake/timeout,
// debug halt/run/step, break, illegal-op trap and retire counter.
module mc_control_unit
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32,
  parameter logic [5:0]  BREAK_FUNCT = 6'h0D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cont,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             PCWriteCond,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegSrcA,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             save_pc,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ALUSrcB,
  output logic             halted,
  output logic             trapped,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired,
  output logic [4:0]       state
);

  state_t           r_state;
  state_t           w_next;
  logic             r_step;
  logic             r_cont_q;
  logic [1:0]       r_err;
  logic [CNT_W-1:0] r_retired;
  logic             w_cont_rise;
  logic             w_retire;
  logic             w_timeout;
  logic             w_mem_active;
  logic             w_wait_clear;
  state_t           w_after;

  assign w_cont_rise  = cont && !r_cont_q;
  assign w_after      = (run && !r_step) ? S_FETCH : S_HALT;
  assign w_mem_active = (r_state == S_FETCH) ||
                        (r_state == S_MEM_READ) ||
                        (r_state == S_MEM_WRITE);
  assign w_wait_clear = (w_next != r_state);

  mc_mem_wait #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_wait (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_wait_clear),
    .i_active  (w_mem_active),
    .i_ready   (mem_ready),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_HALT;
      r_step    <= 1'b0;
      r_cont_q  <= 1'b0;
      r_err     <= ERR_NONE;
      r_retired <= '0;
    end else begin
      r_state  <= w_next;
      r_cont_q <= cont;
      if (r_state == S_HALT && w_next == S_FETCH)
        r_step <= !run;
      if (w_next == S_TRAP && r_state != S_TRAP)
        r_err <= (r_state == S_DECODE) ? ERR_ILLEGAL : ERR_TIMEOUT;
      if (w_retire)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    unique case (r_state)
      S_HALT: begin
        if (run || w_cont_rise) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_DECODE: begin
        unique case (op)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_RTYPE: begin
            if (funct == FN_JR)            w_next = S_JR;
            else if (funct == BREAK_FUNCT) w_next = S_HALT;
            else                           w_next = S_R_EXEC;
          end
          OP_ADDI, OP_SLTI, OP_ANDI,
          OP_ORI, OP_XORI: w_next = S_I_EXEC;
          OP_BEQ, OP_BNE:  w_next = S_BRANCH;
          OP_J:            w_next = S_JUMP;
          OP_JAL:          w_next = S_JAL;
          default:         w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: w_next = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem_ready)      w_next = S_MEM_WB;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          w_next   = w_after;
          w_retire = 1'b1;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_R_EXEC: w_next = S_R_WB;
      S_I_EXEC: w_next = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB,
      S_BRANCH, S_JUMP, S_JAL, S_JR: begin
        w_next   = w_after;
        w_retire = 1'b1;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_HALT;
    endcase
  end

  always_comb begin
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegSrcA     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    save_pc     = 1'b0;
    PCSource    = PCS_PLUS4;
    ALUOp       = ALU_ADD;
    ALUSrcB     = SRCB_RT;
    unique case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_SIMMSH;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SIMM;
      end
      S_MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_RFN;
        if (funct == FN_SLL || funct == FN_SRL) begin
          RegSrcA = 1'b1;
          ALUSrcB = SRCB_SHAMT;
        end
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_IOP;
        ALUSrcB = (op == OP_ADDI || op == OP_SLTI) ? SRCB_SIMM : SRCB_ZIMM;
      end
      S_I_WB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCS_ALU;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
        save_pc  = 1'b1;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = PCS_RS;
      end
      default: ;
    endcase
  end

  assign halted   = (r_state == S_HALT);
  assign trapped  = (r_state == S_TRAP);
  assign err_code = r_err;
  assign retired  = r_retired;
  assign state    = r_state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit with MEM_TIMEOUT=4.
// Each task drives one scenario and checks inline.
module tb_mc_control_unit;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst, run, cont, mem_ready;
  logic [5:0]  op, funct;
  logic        PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
  logic        IRWrite, RegSrcA, ALUSrcA, RegWrite, RegDst, save_pc;
  logic [1:0]  PCSource, ALUOp, err_code;
  logic [2:0]  ALUSrcB;
  logic        halted, trapped;
  logic [31:0] retired;
  logic [4:0]  state;
  logic [18:0] strb;

  int n_chk = 0;
  int n_fail = 0;

  mc_control_unit #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .run(run), .cont(cont), .op(op),
    .funct(funct), .mem_ready(mem_ready),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegSrcA(RegSrcA), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .save_pc(save_pc),
    .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .halted(halted), .trapped(trapped), .err_code(err_code),
    .retired(retired), .state(state)
  );

  assign strb = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
                 IRWrite, RegSrcA, ALUSrcA, RegWrite, RegDst, save_pc,
                 PCSource, ALUOp, ALUSrcB};

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1; run = 1'b0; cont = 1'b0; mem_ready = 1'b0;
    op = 6'h00; funct = 6'h00;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_chk++; if (state !== S_HALT) begin n_fail++;
      $display("FAIL reset_state got=%0d exp=%0d", state, S_HALT); end
    n_chk++; if (strb !== 19'd0) begin n_fail++;
      $display("FAIL reset_strobes got=%h exp=0", strb); end
    n_chk++; if ({halted, trapped} !== 2'b10) begin n_fail++;
      $display("FAIL reset_flags got=%b exp=10", {halted, trapped}); end
    n_chk++; if (err_code !== 2'b00 || retired !== 32'd0) begin n_fail++;
      $display("FAIL reset_err_ret got=%0d/%0d exp=0/0", err_code, retired); end
  endtask

  task automatic test_step;
    cont = 1'b1; op = 6'h08; funct = 6'h00; mem_ready = 1'b1; run = 1'b0;
    #1;
    tick;
    n_chk++; if (state !== S_FETCH || {IRWrite, PCWrite, MemRead} !== 3'b111
                 || ALUSrcB !== 3'b001) begin n_fail++;
      $display("FAIL step_fetch got st=%0d ir/pc/mr=%b srcb=%b exp 1/111/001",
               state, {IRWrite, PCWrite, MemRead}, ALUSrcB); end
    tick;
    n_chk++; if (state !== S_DECODE || ALUSrcB !== 3'b011) begin n_fail++;
      $display("FAIL step_decode got st=%0d srcb=%b exp 2/011", state, ALUSrcB); end
    tick;
    n_chk++; if (state !== S_I_EXEC || ALUOp !== 2'b11 || ALUSrcB !== 3'b010
                 || ALUSrcA !== 1'b1) begin n_fail++;
      $display("FAIL step_iexec got st=%0d aluop=%b srcb=%b exp 9/11/010",
               state, ALUOp, ALUSrcB); end
    tick;
    n_chk++; if (state !== S_I_WB || RegWrite !== 1'b1 || RegDst !== 1'b0)
      begin n_fail++;
      $display("FAIL step_iwb got st=%0d rw=%b rd=%b exp 10/1/0",
               state, RegWrite, RegDst); end
    tick;
    n_chk++; if (state !== S_HALT || retired !== 32'd1) begin n_fail++;
      $display("FAIL step_halt got st=%0d ret=%0d exp 0/1", state, retired); end
    repeat (3) tick;
    n_chk++; if (state !== S_HALT) begin n_fail++;
      $display("FAIL step_cont_held got st=%0d exp 0", state); end
    cont = 1'b0;
    tick;
  endtask

  task automatic test_wait_states;
    state_t exp_st [10];
    int n_mr, n_ir, n_rw;
    exp_st = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEM_ADDR,
               S_MEM_READ, S_MEM_READ, S_MEM_READ, S_MEM_WB};
    n_mr = 0; n_ir = 0; n_rw = 0;
    run = 1'b1; op = 6'h23; mem_ready = 1'b0;
    #1;
    tick;
    for (int k = 0; k < 10; k++) begin
      mem_ready = (k == 3 || k == 8);
      if (k == 1) run = 1'b0;
      #1;
      n_chk++; if (state !== exp_st[k]) begin n_fail++;
        $display("FAIL wait_state k=%0d got=%0d exp=%0d", k, state, exp_st[k]); end
      n_mr += int'(MemRead);
      n_ir += int'(IRWrite);
      n_rw += int'(RegWrite);
      tick;
    end
    n_chk++; if (state !== S_HALT || retired !== 32'd2) begin n_fail++;
      $display("FAIL wait_end got st=%0d ret=%0d exp 0/2", state, retired); end
    n_chk++; if (n_mr != 7 || n_ir != 1 || n_rw != 1) begin n_fail++;
      $display("FAIL wait_counts got mr=%0d ir=%0d rw=%0d exp 7/1/1",
               n_mr, n_ir, n_rw); end
  endtask

  task automatic test_timeout;
    state_t exp_st [8];
    exp_st = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WRITE, S_MEM_WRITE,
               S_MEM_WRITE, S_MEM_WRITE, S_TRAP};
    run = 1'b1; op = 6'h2B; funct = 6'h00;
    #1;
    tick;
    for (int k = 0; k < 8; k++) begin
      mem_ready = (k == 0);
      #1;
      n_chk++; if (state !== exp_st[k]) begin n_fail++;
        $display("FAIL tmo_state k=%0d got=%0d exp=%0d", k, state, exp_st[k]); end
      if (k == 6) begin
        n_chk++; if ({MemWrite, IorD, IRWrite, PCWrite} !== 4'b1100) begin
          n_fail++;
          $display("FAIL tmo_last_wait got=%b exp=1100",
                   {MemWrite, IorD, IRWrite, PCWrite}); end
      end
      tick;
    end
    n_chk++; if (err_code !== 2'b10 || trapped !== 1'b1 || halted !== 1'b0)
      begin n_fail++;
      $display("FAIL tmo_trap got err=%b trap=%b halt=%b exp 10/1/0",
               err_code, trapped, halted); end
    n_chk++; if (strb !== 19'd0 || retired !== 32'd2) begin n_fail++;
      $display("FAIL tmo_strobes got=%h ret=%0d exp 0/2", strb, retired); end
    mem_ready = 1'b1;
    repeat (2) tick;
    n_chk++; if (state !== S_TRAP || err_code !== 2'b10) begin n_fail++;
      $display("FAIL tmo_sticky got st=%0d err=%b exp 15/10", state, err_code); end
  endtask

  task automatic test_illegal;
    run = 1'b1; op = 6'h0D; funct = 6'h00; mem_ready = 1'b1;
    #1;
    tick;
    run = 1'b0;
    tick;
    tick;
    n_chk++; if (state !== S_I_EXEC || ALUSrcB !== 3'b100) begin n_fail++;
      $display("FAIL ori_srcb got st=%0d srcb=%b exp 9/100", state, ALUSrcB); end
    repeat (2) tick;
    n_chk++; if (state !== S_HALT || retired !== 32'd1) begin n_fail++;
      $display("FAIL ori_done got st=%0d ret=%0d exp 0/1", state, retired); end
    run = 1'b1; op = 6'h3F;
    #1;
    repeat (3) tick;
    n_chk++; if (state !== S_TRAP || err_code !== 2'b01 || retired !== 32'd1)
      begin n_fail++;
      $display("FAIL illegal got st=%0d err=%b ret=%0d exp 15/01/1",
               state, err_code, retired); end
    rst = 1'b1;
    #1;
    rst = 1'b0; run = 1'b0;
    #1;
    n_chk++; if (state !== S_HALT || err_code !== 2'b00) begin n_fail++;
      $display("FAIL illegal_rst got st=%0d err=%b exp 0/00", state, err_code); end
    tick;
  endtask

  task automatic test_branch_jumps;
    logic [5:0] ops [5];
    logic [5:0] fns [5];
    state_t     fin [5];
    logic [1:0] pcs [4];
    int         n_sv;
    ops = '{6'h04, 6'h02, 6'h03, 6'h00, 6'h00};
    fns = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0D};
    fin = '{S_BRANCH, S_JUMP, S_JAL, S_JR, S_HALT};
    pcs = '{2'b01, 2'b10, 2'b10, 2'b11};
    n_sv = 0;
    run = 1'b1; mem_ready = 1'b1;
    #1;
    tick;
    for (int i = 0; i < 5; i++) begin
      op = ops[i]; funct = fns[i];
      for (int j = 0; j < 3; j++) begin
        if (i == 4) run = 1'b0;
        #1;
        n_sv += int'(save_pc);
        if (j == 2) begin
          n_chk++; if (state !== fin[i]) begin n_fail++;
            $display("FAIL flow_state i=%0d got=%0d exp=%0d", i, state, fin[i]); end
          if (i < 4) begin
            n_chk++; if (PCSource !== pcs[i] || save_pc !== (i == 2)) begin
              n_fail++;
              $display("FAIL flow_pcs i=%0d got=%b/%b exp=%b/%b",
                       i, PCSource, save_pc, pcs[i], (i == 2)); end
          end
          if (i == 0) begin
            n_chk++; if ({PCWriteCond, PCWrite, ALUOp} !== 4'b1001) begin
              n_fail++;
              $display("FAIL flow_beq got=%b exp=1001",
                       {PCWriteCond, PCWrite, ALUOp}); end
          end
        end
        tick;
      end
    end
    n_chk++; if (state !== S_HALT || retired !== 32'd4 || n_sv != 1) begin
      n_fail++;
      $display("FAIL flow_break got st=%0d ret=%0d sv=%0d exp 0/4/1",
               state, retired, n_sv); end
  endtask

  task automatic test_run_drop;
    run = 1'b1; op = 6'h00; funct = 6'h20; mem_ready = 1'b1;
    #1;
    repeat (3) tick;
    n_chk++; if (state !== S_R_EXEC || {ALUSrcA, RegSrcA, ALUOp, ALUSrcB}
                 !== 7'b1010000) begin n_fail++;
      $display("FAIL add_exec got st=%0d v=%b exp 7/1010000",
               state, {ALUSrcA, RegSrcA, ALUOp, ALUSrcB}); end
    tick;
    n_chk++; if ({RegWrite, RegDst, MemtoReg} !== 3'b110) begin n_fail++;
      $display("FAIL add_wb got=%b exp=110", {RegWrite, RegDst, MemtoReg}); end
    tick;
    funct = 6'h00;
    repeat (2) tick;
    run = 1'b0;
    #1;
    n_chk++; if (state !== S_R_EXEC || RegSrcA !== 1'b1 || ALUSrcB !== 3'b101)
      begin n_fail++;
      $display("FAIL sll_exec got st=%0d rsa=%b srcb=%b exp 7/1/101",
               state, RegSrcA, ALUSrcB); end
    tick;
    n_chk++; if (state !== S_R_WB || RegWrite !== 1'b1) begin n_fail++;
      $display("FAIL drop_wb got st=%0d rw=%b exp 8/1", state, RegWrite); end
    tick;
    n_chk++; if (state !== S_HALT || retired !== 32'd6) begin n_fail++;
      $display("FAIL drop_halt got st=%0d ret=%0d exp 0/6", state, retired); end
  endtask

  task automatic test_async_rst;
    run = 1'b1; op = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
    #1;
    tick;
    run = 1'b0;
    repeat (3) tick;
    mem_ready = 1'b0;
    #1;
    n_chk++; if (state !== S_MEM_WRITE || MemWrite !== 1'b1) begin n_fail++;
      $display("FAIL arst_pre got st=%0d mw=%b exp 6/1", state, MemWrite); end
    #1;
    rst = 1'b1;
    #1;
    n_chk++; if (MemWrite !== 1'b0 || state !== S_HALT || retired !== 32'd0)
      begin n_fail++;
      $display("FAIL arst_now got mw=%b st=%0d ret=%0d exp 0/0/0",
               MemWrite, state, retired); end
    #1;
    rst = 1'b0;
    tick;
    n_chk++; if (strb !== 19'd0 || halted !== 1'b1) begin n_fail++;
      $display("FAIL arst_after got=%h halt=%b exp 0/1", strb, halted); end
  endtask

  initial begin
    test_reset;
    test_step;
    test_wait_states;
    test_timeout;
    test_reset;
    test_illegal;
    test_branch_jumps;
    test_run_drop;
    test_async_rst;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
